// File: rtl/demux_rr_dispatcher.sv
// 1-to-8 demux sequencer: latches one beat, steers it to an addressed or round-robin channel.
// Latency: accept edge -> out_valid next cycle; >=2 cycles/beat; in_ready low while a beat is held.
module demux_rr_dispatcher #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [2:0]       in_dest,
  input  logic             mode,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [DW-1:0]    out_data,
  output logic [2:0]       cur_sel,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state, state_nxt;
  logic [2:0] rr_ptr;
  logic [2:0] rr_pick;
  logic [2:0] rr_idx;
  logic [2:0] target;
  logic       rr_mode;
  logic       accept;
  logic       deliver;

  // Scan from the farthest offset down so the nearest ready channel wins.
  always_comb begin
    rr_pick = rr_ptr;
    rr_idx  = rr_ptr;
    for (int i = 7; i >= 0; i--) begin
      rr_idx = rr_ptr + 3'(i);
      if (out_ready[rr_idx]) rr_pick = rr_idx;
    end
  end

  assign target = mode ? rr_pick : in_dest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 8'h00;
    accept    = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 8'h01 << cur_sel;
        if (out_ready[cur_sel]) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode is captured with the beat so a mid-HOLD change only affects the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      cur_sel  <= 3'd0;
      rr_mode  <= 1'b0;
      rr_ptr   <= 3'd0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        out_data <= in_data;
        cur_sel  <= target;
        rr_mode  <= mode;
      end
      if (deliver) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (rr_mode) rr_ptr <= cur_sel + 3'd1;
      end
    end
  end

endmodule
